// File: rtl/dsm_sample_feeder.sv
// Sample feeder for the delta-sigma DAC: buffers PCM samples and replays one every OSR modulator clocks.
// Latency: a sample popped on a tick appears on data_o one cycle after sample_tick_o; +1 sample period with interpolation.
// Backpressure: s_ready_o is low in IDLE or when the FIFO is full. Optional macro DSM_FEEDER_INTERP_EN enables linear interpolation.
module dsm_sample_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int PREFILL    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [DATA_WIDTH-1:0]         s_data_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          sample_tick_o,
    output logic                          underrun_o,
    output logic                          underrun_sticky_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(OSR);
    localparam logic [DATA_WIDTH-1:0] MID       = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [LW-1:0]         DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]         PREFILL_L = LW'(PREFILL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [CW-1:0]         phase_q, phase_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tick_q, tick_d;
    logic                  underrun_q, underrun_d;
    logic                  sticky_q, sticky_d;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
`ifdef DSM_FEEDER_INTERP_EN
    logic [DATA_WIDTH-1:0]        prev_q, prev_d;
    logic [CW-1:0]                interp_ph;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH+CW+1:0] prod;
`endif

    // Ready depends only on registered state so upstream never sees a combinational loop.
    assign s_ready_o = (state_q != IDLE) && (level_q < DEPTH_L);

    // Next-state, FIFO bookkeeping and tick/underrun decisions.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        phase_d    = phase_q;
        cur_d      = cur_q;
        tick_d     = 1'b0;
        underrun_d = 1'b0;
        sticky_d   = sticky_q;
        push       = s_valid_i && s_ready_o;
        pop        = 1'b0;
`ifdef DSM_FEEDER_INTERP_EN
        prev_d     = prev_q;
`endif
        if (!enable_i || state_q == IDLE) begin
            // Dropping enable flushes everything on the same edge it takes us to IDLE.
            state_d  = enable_i ? PRIME : IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            phase_d  = '0;
            cur_d    = MID;
            sticky_d = 1'b0;
            push     = 1'b0;
`ifdef DSM_FEEDER_INTERP_EN
            prev_d   = MID;
`endif
        end else begin
            if (state_q == PRIME) begin
                if (level_q >= PREFILL_L) begin
                    state_d = RUN;
                end
            end else begin
                phase_d = phase_q + 1'b1;
                if (phase_q == '0) begin
                    tick_d = 1'b1;
`ifdef DSM_FEEDER_INTERP_EN
                    prev_d = cur_q;
`endif
                    // An empty FIFO holds the last value; a same-cycle push is stored, not forwarded.
                    if (level_q != '0) begin
                        pop      = 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        cur_d    = mem_q[rd_ptr_q];
                    end else begin
                        underrun_d = 1'b1;
                        sticky_d   = 1'b1;
                    end
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

`ifdef DSM_FEEDER_INTERP_EN
    // Interpolation runs one phase behind the counter so the first output after a tick equals prev.
    always_comb begin
        interp_ph = phase_q - 1'b1;
        diff      = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
        prod      = diff * $signed({1'b0, interp_ph});
        data_d    = prev_q + DATA_WIDTH'(prod >>> CW);
    end
`else
    // Zero-order hold of the current sample.
    always_comb begin
        data_d = cur_q;
    end
`endif

    // Sample storage; flushing is done through the pointers so the array needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    // State and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            phase_q    <= '0;
            cur_q      <= MID;
            data_q     <= MID;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            sticky_q   <= 1'b0;
`ifdef DSM_FEEDER_INTERP_EN
            prev_q     <= MID;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            phase_q    <= phase_d;
            cur_q      <= cur_d;
            data_q     <= data_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            sticky_q   <= sticky_d;
`ifdef DSM_FEEDER_INTERP_EN
            prev_q     <= prev_d;
`endif
        end
    end

    assign data_o            = data_q;
    assign sample_tick_o     = tick_q;
    assign underrun_o        = underrun_q;
    assign underrun_sticky_o = sticky_q;
    assign level_o           = level_q;

endmodule

// File: tb/tb_dsm_sample_feeder.sv
// Directed bench for dsm_sample_feeder with OSR=4, FIFO_DEPTH=4; PREFILL=2 main instance, PREFILL=4 second instance.
// Latency: checks are taken 1 time unit after each rising edge, against hand-computed cycle positions.
// Backpressure: exercises full-FIFO stall, underrun, enable drop and asynchronous reset.
module tb_dsm_sample_feeder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       enable_i, s_valid_i, s_ready_o;
    logic [7:0] s_data_i, data_o;
    logic       sample_tick_o, underrun_o, underrun_sticky_o;
    logic [2:0] level_o;

    logic       enable4, valid4, ready4;
    logic [7:0] sdata4, data4;
    logic       tick4, underrun4, sticky4;
    logic [2:0] level4;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_i = ~clk_i;

    dsm_sample_feeder #(.DATA_WIDTH(8), .OSR(4), .FIFO_DEPTH(4), .PREFILL(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .data_o(data_o), .sample_tick_o(sample_tick_o), .underrun_o(underrun_o),
        .underrun_sticky_o(underrun_sticky_o), .level_o(level_o)
    );

    dsm_sample_feeder #(.DATA_WIDTH(8), .OSR(4), .FIFO_DEPTH(4), .PREFILL(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable4),
        .s_valid_i(valid4), .s_ready_o(ready4), .s_data_i(sdata4),
        .data_o(data4), .sample_tick_o(tick4), .underrun_o(underrun4),
        .underrun_sticky_o(sticky4), .level_o(level4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00;
        enable4 = 1'b0; valid4 = 1'b0; sdata4 = 8'h00;
        step_n(3);
        check("rst_data", data_o, 8'h80);
        check("rst_rdy", s_ready_o, 1'b0);
        rst_i = 1'b0;
        step_n(2);
        check("idle_data", data_o, 8'h80);
        check("idle_rdy", s_ready_o, 1'b0);
        check("idle_tick", sample_tick_o, 1'b0);
        check("idle_und", underrun_o, 1'b0);
        check("idle_sticky", underrun_sticky_o, 1'b0);
        check("idle_level", level_o, 3'd0);

`ifdef DSM_FEEDER_INTERP_EN
        begin
            logic [7:0] exp_seq [8];
            exp_seq = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h30, 8'h20, 8'h10};
            enable_i = 1'b1; step();
            s_valid_i = 1'b1; s_data_i = 8'h00; step();
            s_data_i = 8'h40; step();
            s_data_i = 8'h00; step();
            s_valid_i = 1'b0;
            step_n(5);
            check("int_tick", sample_tick_o, 1'b1);
            for (int i = 0; i < 8; i++) begin
                step();
                check($sformatf("interp%0d", i), data_o, exp_seq[i]);
            end
        end
`else
        // PREFILL=4 instance: fill to full while stalled in PRIME, 5th valid refused.
        enable4 = 1'b1; step();
        valid4 = 1'b1; sdata4 = 8'hA1; step();
        sdata4 = 8'hA2; step();
        sdata4 = 8'hA3; step();
        sdata4 = 8'hA4; step();
        check("p4_full_lvl", level4, 3'd4);
        check("p4_full_rdy", ready4, 1'b0);
        sdata4 = 8'hA5; step();
        check("p4_no5th", level4, 3'd4);
        step();
        check("p4_tick", tick4, 1'b1);
        check("p4_lvl3", level4, 3'd3);
        valid4 = 1'b0; step();
        check("p4_dA1", data4, 8'hA1);
        step_n(4); check("p4_dA2", data4, 8'hA2);
        step_n(4); check("p4_dA3", data4, 8'hA3);
        step_n(4); check("p4_dA4", data4, 8'hA4);
        check("p4_empty", level4, 3'd0);
        step_n(3);
        check("p4_under", underrun4, 1'b1);
        enable4 = 1'b0;

        // Main instance: priming, playback cadence, underrun and recovery.
        enable_i = 1'b1; step();
        check("prime_rdy", s_ready_o, 1'b1);
        s_valid_i = 1'b1; s_data_i = 8'h10; step();
        check("lvl1", level_o, 3'd1);
        s_data_i = 8'h20; step();
        s_data_i = 8'h30; step();
        check("lvl3", level_o, 3'd3);
        s_valid_i = 1'b0; step();
        check("tick1", sample_tick_o, 1'b1);
        check("tick1_data", data_o, 8'h80);
        step();
        check("d10", data_o, 8'h10);
        check("tick1_end", sample_tick_o, 1'b0);
        step_n(2);
        check("no_tick", sample_tick_o, 1'b0);
        step();
        check("tick2", sample_tick_o, 1'b1);
        step();
        check("d20", data_o, 8'h20);
        step_n(3);
        check("tick3", sample_tick_o, 1'b1);
        check("lvl0", level_o, 3'd0);
        step();
        check("d30", data_o, 8'h30);
        s_valid_i = 1'b1; s_data_i = 8'h40; step();
        s_valid_i = 1'b0; step_n(2);
        check("tick4_no_und", underrun_o, 1'b0);
        step();
        check("d40", data_o, 8'h40);
        step_n(3);
        check("und_pulse", underrun_o, 1'b1);
        check("und_sticky", underrun_sticky_o, 1'b1);
        check("und_hold", data_o, 8'h40);
        step();
        check("und_end", underrun_o, 1'b0);
        check("sticky_hold", underrun_sticky_o, 1'b1);
        s_valid_i = 1'b1; s_data_i = 8'h50; step();
        s_valid_i = 1'b0; step_n(2);
        check("resume_no_und", underrun_o, 1'b0);
        step();
        check("d50", data_o, 8'h50);
        check("sticky_stays", underrun_sticky_o, 1'b1);
        step_n(2);
        s_valid_i = 1'b1; s_data_i = 8'h60; step();
        check("pe_und", underrun_o, 1'b1);
        check("pe_stored", level_o, 3'd1);
        check("pe_hold", data_o, 8'h50);
        s_valid_i = 1'b0; step_n(3);
        s_valid_i = 1'b1; s_data_i = 8'h70; step();
        check("pp_level", level_o, 3'd1);
        check("pp_no_und", underrun_o, 1'b0);
        s_data_i = 8'h71; step();
        check("d60", data_o, 8'h60);
        s_data_i = 8'h72; step();
        check("pre_drop_lvl", level_o, 3'd3);
        s_valid_i = 1'b0; enable_i = 1'b0; step();
        check("drop_lvl", level_o, 3'd0);
        check("drop_rdy", s_ready_o, 1'b0);
        check("drop_data_old", data_o, 8'h60);
        step();
        check("drop_data_mid", data_o, 8'h80);
        check("drop_sticky", underrun_sticky_o, 1'b0);

        // Asynchronous reset in the middle of playback.
        enable_i = 1'b1; step();
        s_valid_i = 1'b1; s_data_i = 8'h11; step();
        s_data_i = 8'h22; step();
        s_valid_i = 1'b0; step_n(3);
        check("pre_rst_d11", data_o, 8'h11);
        check("pre_rst_lvl", level_o, 3'd1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_data", data_o, 8'h80);
        check("arst_lvl", level_o, 3'd0);
        check("arst_rdy", s_ready_o, 1'b0);
        step();
        rst_i = 1'b0; enable_i = 1'b0;
`endif
        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
